// File: rtl/cmp_config_parser_if.sv
`default_nettype none
// ============================================================================
// Module   : cmp_config_parser_if
// Purpose  : Bundles the body-byte stream from the header stage and the
//            configuration bus towards the descrypt comparator.
// Ports    : stream   - din, pkt_end, empty (to parser), rd_en (from parser)
//            cmp side - cmp_busy (to parser); salt, num_hashes, hash_dout,
//                       hash_addr, hash_wr_en, config_valid, new_config,
//                       err (from parser)
// Modports : master - the parser's view; slave - the surrounding system.
// Revision : 1.0 - initial release
// ============================================================================
interface cmp_config_parser_if #(
    parameter int HASH_ADDR_WIDTH = 10
);
    logic [7:0]                 din;
    logic                       pkt_end;
    logic                       empty;
    logic                       rd_en;
    logic                       cmp_busy;
    logic [11:0]                salt;
    logic [15:0]                num_hashes;
    logic [34:0]                hash_dout;
    logic [HASH_ADDR_WIDTH-1:0] hash_addr;
    logic                       hash_wr_en;
    logic                       config_valid;
    logic                       new_config;
    logic [3:0]                 err;

    modport master (
        input  din, pkt_end, empty, cmp_busy,
        output rd_en, salt, num_hashes, hash_dout, hash_addr, hash_wr_en,
               config_valid, new_config, err
    );

    modport slave (
        output din, pkt_end, empty, cmp_busy,
        input  rd_en, salt, num_hashes, hash_dout, hash_addr, hash_wr_en,
               config_valid, new_config, err
    );
endinterface
`default_nettype wire

// File: rtl/cmp_config_parser.sv
`default_nettype none
// ============================================================================
// Module   : cmp_config_parser
// Purpose  : Parses the body of a cmp_config packet (salt, hash count, hash
//            list, trailing magic byte) and loads the comparator's salt,
//            hash count and hash RAM. Raises sticky error flags on a bad
//            count, bad magic, length mismatch or (optionally) unsorted hashes.
// Ports    : clk    - packet-comm clock
//            rst_n  - asynchronous active-low reset
//            bus    - cmp_config_parser_if.master (byte stream + comparator bus)
// Options  : CMP_CONFIG_SORT_CHECK_EN - when defined, each hash is compared
//            with the previous one; a strictly smaller value sets err[3].
// Revision : 1.0 - initial release
// ============================================================================
module cmp_config_parser #(
    parameter int         HASH_ADDR_WIDTH = 10,
    parameter int         HASH_MAX        = 1024,
    parameter logic [7:0] MAGIC           = 8'hCC
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    cmp_config_parser_if.master   bus
);

    localparam logic [16:0] c_HASH_MAX = 17'(HASH_MAX);

    typedef enum logic [3:0] {
        S_SALT0   = 4'd0,
        S_SALT1   = 4'd1,
        S_CNT0    = 4'd2,
        S_CNT1    = 4'd3,
        S_HASH    = 4'd4,
        S_MAGIC   = 4'd5,
        S_DONE    = 4'd6,
        S_DISCARD = 4'd7
    } state_t;

    state_t                     r_state;
    state_t                     w_state_next;

    logic [11:0]                r_salt;
    logic [15:0]                r_num_hashes;
    logic [31:0]                r_shift;       // previous four bytes of the current hash
    logic [2:0]                 r_byte_cnt;
    logic [15:0]                r_hash_cnt;
    logic [34:0]                r_hash_dout;
    logic [HASH_ADDR_WIDTH-1:0] r_hash_addr;
    logic                       r_hash_wr_en;
    logic                       r_config_valid;
    logic                       r_new_config;
    logic [2:0]                 r_err;
    logic                       w_err3;

    logic                       w_rd_en;
    logic [15:0]                w_count;
    logic                       w_count_bad;
    logic [34:0]                w_hash;
    logic                       w_hash_last_byte;
    logic                       w_last_hash;
    logic                       w_sort_err;
    logic                       w_magic_ok;

    // Reset gates the read strobe so nothing is consumed while held in reset.
    assign w_rd_en = rst_n && !bus.empty
                   && !(r_state == S_SALT0 && bus.cmp_busy)
                   && (r_state != S_DONE);

    assign w_count          = {bus.din, r_num_hashes[7:0]};
    assign w_count_bad      = (w_count == 16'd0) || ({1'b0, w_count} > c_HASH_MAX);
    // Little-endian: the incoming byte is the most significant of the five.
    assign w_hash           = {bus.din[2:0], r_shift};
    assign w_hash_last_byte = (r_byte_cnt == 3'd4);
    assign w_last_hash      = (r_hash_cnt == (r_num_hashes - 16'd1));
    assign w_magic_ok       = (bus.din == MAGIC);

`ifdef CMP_CONFIG_SORT_CHECK_EN
    logic [34:0] r_prev_hash;
    logic        r_sort_err;

    assign w_sort_err = (r_hash_cnt != 16'd0) && (w_hash < r_prev_hash);
    assign w_err3     = r_sort_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev_hash <= '0;
            r_sort_err  <= 1'b0;
        end else if (w_rd_en && r_state == S_HASH && w_hash_last_byte) begin
            r_prev_hash <= w_hash;
            if (w_sort_err) begin
                r_sort_err <= 1'b1;
            end
        end
    end
`else
    assign w_sort_err = 1'b0;
    assign w_err3     = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_SALT0;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state. A pkt_end seen before the magic byte is a truncated
    // body; that byte is still consumed and parsing restarts.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_SALT0: if (w_rd_en) w_state_next = bus.pkt_end ? S_SALT0 : S_SALT1;
            S_SALT1: if (w_rd_en) w_state_next = bus.pkt_end ? S_SALT0 : S_CNT0;
            S_CNT0:  if (w_rd_en) w_state_next = bus.pkt_end ? S_SALT0 : S_CNT1;
            S_CNT1: begin
                if (w_rd_en) begin
                    if (bus.pkt_end)      w_state_next = S_SALT0;
                    else if (w_count_bad) w_state_next = S_DISCARD;
                    else                  w_state_next = S_HASH;
                end
            end
            S_HASH: begin
                if (w_rd_en) begin
                    if (bus.pkt_end)                          w_state_next = S_SALT0;
                    else if (w_hash_last_byte && w_sort_err)  w_state_next = S_DISCARD;
                    else if (w_hash_last_byte && w_last_hash) w_state_next = S_MAGIC;
                end
            end
            S_MAGIC: begin
                if (w_rd_en) begin
                    if (!bus.pkt_end)    w_state_next = S_DISCARD;
                    else if (w_magic_ok) w_state_next = S_DONE;
                    else                 w_state_next = S_SALT0;
                end
            end
            S_DONE:    w_state_next = S_SALT0;
            S_DISCARD: if (w_rd_en && bus.pkt_end) w_state_next = S_SALT0;
            default:   w_state_next = S_SALT0;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: field capture, RAM write strobe, status and errors
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_salt         <= '0;
            r_num_hashes   <= '0;
            r_shift        <= '0;
            r_byte_cnt     <= '0;
            r_hash_cnt     <= '0;
            r_hash_dout    <= '0;
            r_hash_addr    <= '0;
            r_hash_wr_en   <= 1'b0;
            r_config_valid <= 1'b0;
            r_new_config   <= 1'b0;
            r_err          <= '0;
        end else begin
            r_hash_wr_en <= 1'b0;
            r_new_config <= 1'b0;
            if (w_rd_en) begin
                case (r_state)
                    S_SALT0: begin
                        r_salt[7:0]    <= bus.din;
                        r_config_valid <= 1'b0;
                        if (bus.pkt_end) r_err[2] <= 1'b1;
                    end
                    S_SALT1: begin
                        r_salt[11:8] <= bus.din[3:0];
                        if (bus.pkt_end) r_err[2] <= 1'b1;
                    end
                    S_CNT0: begin
                        r_num_hashes[7:0] <= bus.din;
                        if (bus.pkt_end) r_err[2] <= 1'b1;
                    end
                    S_CNT1: begin
                        r_num_hashes[15:8] <= bus.din;
                        r_hash_cnt         <= '0;
                        r_byte_cnt         <= '0;
                        if (bus.pkt_end)      r_err[2] <= 1'b1;
                        else if (w_count_bad) r_err[0] <= 1'b1;
                    end
                    S_HASH: begin
                        r_shift <= {bus.din, r_shift[31:8]};
                        if (w_hash_last_byte) begin
                            r_byte_cnt   <= '0;
                            r_hash_wr_en <= 1'b1;
                            r_hash_dout  <= w_hash;
                            r_hash_addr  <= r_hash_cnt[HASH_ADDR_WIDTH-1:0];
                            r_hash_cnt   <= r_hash_cnt + 16'd1;
                        end else begin
                            r_byte_cnt <= r_byte_cnt + 3'd1;
                        end
                        if (bus.pkt_end) r_err[2] <= 1'b1;
                    end
                    S_MAGIC: begin
                        if (!w_magic_ok) r_err[1] <= 1'b1;
                        if (!bus.pkt_end) begin
                            r_err[2] <= 1'b1;
                        end else if (w_magic_ok) begin
                            // Valid and new_config rise together, one cycle after the magic byte.
                            r_new_config   <= 1'b1;
                            r_config_valid <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.rd_en        = w_rd_en;
    assign bus.salt         = r_salt;
    assign bus.num_hashes   = r_num_hashes;
    assign bus.hash_dout    = r_hash_dout;
    assign bus.hash_addr    = r_hash_addr;
    assign bus.hash_wr_en   = r_hash_wr_en;
    assign bus.config_valid = r_config_valid;
    assign bus.new_config   = r_new_config;
    assign bus.err          = {w_err3, r_err};

endmodule
`default_nettype wire

// File: tb/tb_cmp_config_parser.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_cmp_config_parser
// Purpose  : Directed scoreboard bench for cmp_config_parser. Expected RAM
//            writes and config loads are queued ahead of each packet and a
//            monitor pops and compares them as the DUT presents them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cmp_config_parser;

    localparam int AW = 10;

    typedef struct {
        logic [AW-1:0] addr;
        logic [34:0]   data;
    } wr_t;

    typedef struct {
        logic [11:0] salt;
        logic [15:0] num;
    } nc_t;

    logic clk;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;
    time  t_last  = 0;

    wr_t        wq[$];
    nc_t        ncq[$];
    logic [7:0] pkt[$];

    cmp_config_parser_if #(.HASH_ADDR_WIDTH(AW)) bus ();

    cmp_config_parser #(
        .HASH_ADDR_WIDTH(AW),
        .HASH_MAX       (1024),
        .MAGIC          (8'hCC)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    // Monitor: every RAM write and every new_config pulse must match the head
    // of its expectation queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.hash_wr_en) begin
                if (wq.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_write: got addr %0d data %h, expected no write",
                             bus.hash_addr, bus.hash_dout);
                end else begin
                    wr_t e;
                    e = wq.pop_front();
                    check("wr_addr", 64'(bus.hash_addr), 64'(e.addr));
                    check("wr_data", 64'(bus.hash_dout), 64'(e.data));
                end
            end
            if (bus.new_config) begin
                if (ncq.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_new_config: got salt %h num %0d, expected no pulse",
                             bus.salt, bus.num_hashes);
                end else begin
                    nc_t e;
                    e = ncq.pop_front();
                    check("nc_salt", 64'(bus.salt), 64'(e.salt));
                    check("nc_num_hashes", 64'(bus.num_hashes), 64'(e.num));
                    check("nc_config_valid", 64'(bus.config_valid), 64'd1);
                    check("nc_latency", 64'($time - t_last), 64'd5);
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge after the byte was taken.
    task automatic send_byte(input logic [7:0] b, input logic last);
        int t;
        t = 0;
        bus.din     = b;
        bus.pkt_end = last;
        bus.empty   = 1'b0;
        #1;
        while (!bus.rd_en && t < 100) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (!bus.rd_en) begin
            n_tests++;
            n_fail++;
            $display("FAIL rd_en_timeout: got rd_en 0, expected 1 within 100 cycles");
        end
        @(posedge clk);
        t_last = $time;
        @(negedge clk);
    endtask

    task automatic send_pkt();
        for (int i = 0; i < pkt.size(); i++) begin
            send_byte(pkt[i], (i == pkt.size() - 1));
        end
        bus.empty   = 1'b1;
        bus.pkt_end = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic push_wr(input logic [AW-1:0] a, input logic [34:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        wq.push_back(e);
    endtask

    task automatic push_nc(input logic [11:0] s, input logic [15:0] n);
        nc_t e;
        e.salt = s;
        e.num  = n;
        ncq.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n        = 1'b0;
        bus.din      = 8'h00;
        bus.pkt_end  = 1'b0;
        bus.empty    = 1'b1;
        bus.cmp_busy = 1'b0;
        #3;
        check("rst_err",          64'(bus.err),          64'd0);
        check("rst_config_valid", 64'(bus.config_valid), 64'd0);
        check("rst_salt",         64'(bus.salt),         64'd0);
        check("rst_num_hashes",   64'(bus.num_hashes),   64'd0);
        check("rst_hash_addr",    64'(bus.hash_addr),    64'd0);
        check("rst_hash_dout",    64'(bus.hash_dout),    64'd0);
        check("rst_hash_wr_en",   64'(bus.hash_wr_en),   64'd0);
        check("rst_new_config",   64'(bus.new_config),   64'd0);
        check("rst_rd_en",        64'(bus.rd_en),        64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: reference two-hash config
        pkt = '{8'hC7, 8'h01, 8'h02, 8'h00, 8'hAD, 8'h31, 8'h87, 8'hCC, 8'hE3,
                8'hCB, 8'h68, 8'h00, 8'h08, 8'h8F, 8'hCC};
        push_wr(10'd0, 35'h3CC8731AD);
        push_wr(10'd1, 35'h7080068CB);
        push_nc(12'h1C7, 16'd2);
        send_pkt();
        check("p1_config_valid", 64'(bus.config_valid), 64'd1);
        check("p1_err",          64'(bus.err),          64'd0);
        check("p1_salt",         64'(bus.salt),         64'h1C7);
        check("p1_num_hashes",   64'(bus.num_hashes),   64'd2);

        // 2: zero hash count, rest of body discarded
        pkt = '{8'hC7, 8'h01, 8'h00, 8'h00, 8'h11, 8'h22, 8'hCC};
        send_pkt();
        check("p2_err",          64'(bus.err),          64'h1);
        check("p2_config_valid", 64'(bus.config_valid), 64'd0);

        // 3: ten equal hashes, bad magic
        pkt = '{8'h34, 8'h12, 8'h0A, 8'h00};
        for (int i = 0; i < 50; i++) pkt.push_back(8'hBB);
        pkt.push_back(8'hCD);
        for (int i = 0; i < 10; i++) push_wr(AW'(i), 35'h3BBBBBBBB);
        send_pkt();
        check("p3_err",          64'(bus.err),          64'h3);
        check("p3_config_valid", 64'(bus.config_valid), 64'd0);

        // 4: valid one-hash config after errors
        pkt = '{8'h55, 8'h0A, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'hCC};
        push_wr(10'd0, 35'h504030201);
        push_nc(12'hA55, 16'd1);
        send_pkt();
        check("p4_config_valid", 64'(bus.config_valid), 64'd1);
        check("p4_err",          64'(bus.err),          64'h3);

        // 5: two-hash body truncated on byte 12
        pkt = '{8'hC7, 8'h01, 8'h02, 8'h00, 8'hAD, 8'h31, 8'h87, 8'hCC, 8'hE3,
                8'hCB, 8'h68, 8'h00};
        push_wr(10'd0, 35'h3CC8731AD);
        send_pkt();
        check("p5_err",          64'(bus.err),          64'h7);
        check("p5_config_valid", 64'(bus.config_valid), 64'd0);

        // 6: reference config again, parser must have resynchronised
        pkt = '{8'hC7, 8'h01, 8'h02, 8'h00, 8'hAD, 8'h31, 8'h87, 8'hCC, 8'hE3,
                8'hCB, 8'h68, 8'h00, 8'h08, 8'h8F, 8'hCC};
        push_wr(10'd0, 35'h3CC8731AD);
        push_wr(10'd1, 35'h7080068CB);
        push_nc(12'h1C7, 16'd2);
        send_pkt();
        check("p6_config_valid", 64'(bus.config_valid), 64'd1);
        check("p6_err",          64'(bus.err),          64'h7);

        // 7: comparator busy holds off the first byte; descending hashes
        bus.cmp_busy = 1'b1;
        bus.din      = 8'h42;
        bus.pkt_end  = 1'b0;
        bus.empty    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("busy_rd_en", 64'(bus.rd_en), 64'd0);
            @(negedge clk);
        end
        check("busy_salt_held", 64'(bus.salt), 64'h1C7);
        bus.cmp_busy = 1'b0;
        #1;
        check("unbusy_rd_en", 64'(bus.rd_en), 64'd1);
        pkt = '{8'h42, 8'h03, 8'h02, 8'h00, 8'hCB, 8'h68, 8'h00, 8'h08, 8'h8F,
                8'hAD, 8'h31, 8'h87, 8'hCC, 8'hE3, 8'hCC};
        push_wr(10'd0, 35'h7080068CB);
        push_wr(10'd1, 35'h3CC8731AD);
`ifdef CMP_CONFIG_SORT_CHECK_EN
        send_pkt();
        check("p7_config_valid", 64'(bus.config_valid), 64'd0);
        check("p7_err",          64'(bus.err),          64'hF);
`else
        push_nc(12'h342, 16'd2);
        send_pkt();
        check("p7_config_valid", 64'(bus.config_valid), 64'd1);
        check("p7_err",          64'(bus.err),          64'h7);
`endif

        repeat (5) @(negedge clk);
        check("writes_drained",     64'(wq.size()),  64'd0);
        check("new_config_drained", 64'(ncq.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
